// File: rtl/arb8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: requester count,
// FSM state encodings and the circular priority search.
package arb8_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    // First set request bit at or above ptr, wrapping past the top requester.
    // The caller only uses the result when at least one request is set.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Priority pointer after an owner lets go: the slot just above it,
    // with the top requester wrapping to 0 through the 3-bit overflow.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        next_ptr = idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/dec3to8.sv
// Enabled 3-to-8 one-hot decoder; output is all zero when en is low.
module dec3to8 (
    input  logic [2:0] a,
    input  logic       en,
    output logic [7:0] s
);

    // Single bit set at position a, only while enabled.
    always_comb begin
        s = 8'h00;
        if (en) begin
            s[a] = 1'b1;
        end
    end

endmodule

// File: rtl/arb8_rr.sv
// 8-way round-robin arbiter with per-grant hold limit and timeout flag.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no grant; arbitrate from ptr whenever any req is set
//   ST_GRANT   | gnt_idx owns the resource; hold_cnt counts grant cycles
//   ST_RELEASE | one-cycle dead gap after a grant; may arbitrate again
//
// A grant ends on done, on the owner dropping its request, or when it has
// been held for MAX_HOLD cycles. Only the last cause on its own raises
// to_err during the release cycle.
module arb8_rr
    import arb8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             to_err
);

    localparam int unsigned      HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  gnt_idx_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              gnt_vld_q;
    logic              to_err_q;

    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  ptr_d;
    logic              owner_req;
    logic              hold_last;
    logic              release_now;
    logic              timeout_only;

    // Arbitration result and grant-termination conditions for this cycle.
    always_comb begin
        winner       = rr_pick(req, ptr_q);
        ptr_d        = next_ptr(gnt_idx_q);
        owner_req    = req[gnt_idx_q];
        hold_last    = (hold_cnt_q == HOLD_LAST);
        release_now  = done || !owner_req || hold_last;
        timeout_only = hold_last && !done && owner_req;
    end

    // Arbiter FSM with all state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            hold_cnt_q <= '0;
            gnt_vld_q  <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            to_err_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RELEASE: begin
                    if (|req) begin
                        state_q    <= ST_GRANT;
                        gnt_idx_q  <= winner;
                        hold_cnt_q <= '0;
                        gnt_vld_q  <= 1'b1;
                    end else begin
                        state_q   <= ST_IDLE;
                        gnt_vld_q <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state_q   <= ST_RELEASE;
                        gnt_vld_q <= 1'b0;
                        ptr_q     <= ptr_d;
                        to_err_q  <= timeout_only;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    gnt_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // One-hot grant decoded from the registered owner index.
    dec3to8 u_dec (
        .a  (gnt_idx_q),
        .en (gnt_vld_q),
        .s  (gnt)
    );

    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign to_err  = to_err_q;

endmodule
